// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: accepts exceptions, mret and external interrupts,
// then issues the mepc/mcause/mstatus CSR writes and the PC redirect.
module trap_ctrl #(
  parameter bit MTVEC_VEC_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        illegal_req,
  input  logic        ebreak_req,
  input  logic        ecall_req,
  input  logic        mret_req,
  input  logic        irq_ext,
  input  logic [31:0] req_pc,
  input  logic [31:0] mstatus_in,
  input  logic [31:0] mepc_in,
  input  logic [31:0] mtvec_in,
  output logic        csr_we,
  output logic [11:0] csr_addr,
  output logic [31:0] csr_wdata,
  output logic        busy,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  typedef enum logic [2:0] {
    IDLE,
    FLUSH,
    W_MEPC,
    W_MCAUSE,
    W_MSTATUS,
    REDIRECT
  } state_t;

  typedef enum logic [2:0] {
    K_ILLEGAL,
    K_EBREAK,
    K_ECALL,
    K_MRET,
    K_IRQ
  } kind_t;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [31:0] CAUSE_ILLEGAL = 32'd2;
  localparam logic [31:0] CAUSE_EBREAK  = 32'd3;
  localparam logic [31:0] CAUSE_ECALL   = 32'd11;
  localparam logic [31:0] CAUSE_IRQ     = 32'h8000_000B;

  state_t      state;
  kind_t       lat_kind;
  logic [31:0] lat_mcause;
  logic [31:0] lat_pc;
  logic [31:0] lat_mstatus;
  logic [31:0] lat_mepc;
  logic [31:0] lat_mtvec;

  logic        accept;
  kind_t       sel_kind;
  logic [31:0] sel_cause;

  // Fixed priority: illegal > ebreak > ecall > mret > irq. Synchronous kinds
  // need req_valid; the interrupt only needs the global MIE bit.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    accept    = 1'b0;
    sel_kind  = K_ILLEGAL;
    sel_cause = '0;
    if (req_valid && illegal_req) begin
      accept    = 1'b1;
      sel_kind  = K_ILLEGAL;
      sel_cause = CAUSE_ILLEGAL;
    end else if (req_valid && ebreak_req) begin
      accept    = 1'b1;
      sel_kind  = K_EBREAK;
      sel_cause = CAUSE_EBREAK;
    end else if (req_valid && ecall_req) begin
      accept    = 1'b1;
      sel_kind  = K_ECALL;
      sel_cause = CAUSE_ECALL;
    end else if (req_valid && mret_req) begin
      accept    = 1'b1;
      sel_kind  = K_MRET;
      sel_cause = '0;
    end else if (irq_ext && mstatus_in[3]) begin
      accept    = 1'b1;
      sel_kind  = K_IRQ;
      sel_cause = CAUSE_IRQ;
    end
  end

  function automatic logic [31:0] trap_mstatus(input logic [31:0] m);
    logic [31:0] r;
    r       = m;
    r[7]    = m[3];
    r[3]    = 1'b0;
    r[12:11] = 2'b11;
    return r;
  endfunction

  function automatic logic [31:0] mret_mstatus(input logic [31:0] m);
    logic [31:0] r;
    r    = m;
    r[3] = m[7];
    r[7] = 1'b1;
    return r;
  endfunction

  // Vectored mode only offsets interrupts; exceptions always land on the base.
  function automatic logic [31:0] trap_target(input logic [31:0] tvec, input kind_t kind);
    logic [31:0] base;
    base = {tvec[31:2], 2'b00};
    if (MTVEC_VEC_EN && (tvec[1:0] == 2'b01) && (kind == K_IRQ))
      return base + 32'd44;
    return base;
  endfunction

  assign busy = (state != IDLE);

  // Outputs are registered alongside the state: each transition loads the
  // values that belong to the state being entered.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      // NOTE: latched fields are cleared too so an aborted operation leaves
      // nothing behind that a later sequence could observe.
      lat_kind       <= K_ILLEGAL;
      lat_mcause     <= '0;
      lat_pc         <= '0;
      lat_mstatus    <= '0;
      lat_mepc       <= '0;
      lat_mtvec      <= '0;
      flush          <= 1'b0;
      csr_we         <= 1'b0;
      csr_addr       <= '0;
      csr_wdata      <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      flush          <= 1'b0;
      csr_we         <= 1'b0;
      csr_addr       <= '0;
      csr_wdata      <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;

      case (state)
        IDLE: begin
          if (accept) begin
            lat_kind    <= sel_kind;
            lat_mcause  <= sel_cause;
            lat_pc      <= req_pc;
            lat_mstatus <= mstatus_in;
            lat_mepc    <= mepc_in;
            lat_mtvec   <= mtvec_in;
            state       <= FLUSH;
            flush       <= 1'b1;
          end
        end

        FLUSH: begin
          csr_we <= 1'b1;
          if (lat_kind == K_MRET) begin
            state     <= W_MSTATUS;
            csr_addr  <= CSR_MSTATUS;
            csr_wdata <= mret_mstatus(lat_mstatus);
          end else begin
            state     <= W_MEPC;
            csr_addr  <= CSR_MEPC;
            csr_wdata <= {lat_pc[31:2], 2'b00};
          end
        end

        W_MEPC: begin
          state     <= W_MCAUSE;
          csr_we    <= 1'b1;
          csr_addr  <= CSR_MCAUSE;
          csr_wdata <= lat_mcause;
        end

        W_MCAUSE: begin
          state     <= W_MSTATUS;
          csr_we    <= 1'b1;
          csr_addr  <= CSR_MSTATUS;
          csr_wdata <= trap_mstatus(lat_mstatus);
        end

        W_MSTATUS: begin
          state          <= REDIRECT;
          redirect_valid <= 1'b1;
          if (lat_kind == K_MRET)
            redirect_pc <= {lat_mepc[31:2], 2'b00};
          else
            redirect_pc <= trap_target(lat_mtvec, lat_kind);
        end

        REDIRECT: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: walks each sequence cycle by cycle against
// hand-computed CSR writes and redirect targets.
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, illegal_req, ebreak_req, ecall_req, mret_req, irq_ext;
  logic [31:0] req_pc, mstatus_in, mepc_in, mtvec_in;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        busy, flush, redirect_valid;
  logic [31:0] redirect_pc;

  int n_checks = 0;
  int n_errors = 0;

  trap_ctrl #(.MTVEC_VEC_EN(1'b1)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .illegal_req    (illegal_req),
    .ebreak_req     (ebreak_req),
    .ecall_req      (ecall_req),
    .mret_req       (mret_req),
    .irq_ext        (irq_ext),
    .req_pc         (req_pc),
    .mstatus_in     (mstatus_in),
    .mepc_in        (mepc_in),
    .mtvec_in       (mtvec_in),
    .csr_we         (csr_we),
    .csr_addr       (csr_addr),
    .csr_wdata      (csr_wdata),
    .busy           (busy),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic b, input logic f, input logic we,
                            input logic [11:0] a, input logic [31:0] d,
                            input logic rv, input logic [31:0] rp);
    check({tag, ".busy"},        {31'd0, busy},           {31'd0, b});
    check({tag, ".flush"},       {31'd0, flush},          {31'd0, f});
    check({tag, ".csr_we"},      {31'd0, csr_we},         {31'd0, we});
    check({tag, ".csr_addr"},    {20'd0, csr_addr},       {20'd0, a});
    check({tag, ".csr_wdata"},   csr_wdata,               d);
    check({tag, ".redir_valid"}, {31'd0, redirect_valid}, {31'd0, rv});
    check({tag, ".redir_pc"},    redirect_pc,             rp);
  endtask

  task automatic clear_reqs(input logic hold_irq);
    req_valid   = 1'b0;
    illegal_req = 1'b0;
    ebreak_req  = 1'b0;
    ecall_req   = 1'b0;
    mret_req    = 1'b0;
    irq_ext     = hold_irq;
  endtask

  // Scrambled CSR inputs after acceptance expose any field that was not latched;
  // MIE is kept clear so a held irq cannot start a new sequence.
  task automatic scramble();
    req_pc     = 32'hA5A5_5A5A;
    mstatus_in = 32'hFFFF_FFF7;
    mepc_in    = 32'h1357_9BDF;
    mtvec_in   = 32'hDEAD_BEE1;
  endtask

  task automatic run_trap(input string tag, input logic hold_irq, input logic [31:0] e_mepc,
                          input logic [31:0] e_cause, input logic [31:0] e_mstatus,
                          input logic [31:0] e_rpc);
    step();
    clear_reqs(hold_irq);
    scramble();
    expect_out({tag, ":flush"},   1, 1, 0, 12'h000, 32'h0, 0, 32'h0); step();
    expect_out({tag, ":mepc"},    1, 0, 1, 12'h341, e_mepc, 0, 32'h0); step();
    expect_out({tag, ":mcause"},  1, 0, 1, 12'h342, e_cause, 0, 32'h0); step();
    expect_out({tag, ":mstatus"}, 1, 0, 1, 12'h300, e_mstatus, 0, 32'h0); step();
    expect_out({tag, ":redir"},   1, 0, 0, 12'h000, 32'h0, 1, e_rpc); step();
    expect_out({tag, ":idle"},    0, 0, 0, 12'h000, 32'h0, 0, 32'h0);
  endtask

  task automatic run_mret(input string tag, input logic [31:0] e_mstatus, input logic [31:0] e_rpc);
    step();
    clear_reqs(1'b0);
    scramble();
    expect_out({tag, ":flush"},   1, 1, 0, 12'h000, 32'h0, 0, 32'h0); step();
    expect_out({tag, ":mstatus"}, 1, 0, 1, 12'h300, e_mstatus, 0, 32'h0); step();
    expect_out({tag, ":redir"},   1, 0, 0, 12'h000, 32'h0, 1, e_rpc); step();
    expect_out({tag, ":idle"},    0, 0, 0, 12'h000, 32'h0, 0, 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    clear_reqs(1'b0);
    req_pc = '0; mstatus_in = '0; mepc_in = '0; mtvec_in = '0;
    step();
    step();
    expect_out("reset", 0, 0, 0, 12'h000, 32'h0, 0, 32'h0);
    rst = 1'b0;
    step();
    expect_out("idle_no_req", 0, 0, 0, 12'h000, 32'h0, 0, 32'h0);

    // ecall: mstatus 0x8 -> 0x1880, target mtvec base
    req_valid = 1; ecall_req = 1; req_pc = 32'h104; mstatus_in = 32'h8; mtvec_in = 32'h200;
    run_trap("ecall", 1'b0, 32'h104, 32'd11, 32'h1880, 32'h200);

    // mret: MIE <= MPIE, MPIE <= 1
    req_valid = 1; mret_req = 1; mstatus_in = 32'h1880; mepc_in = 32'h108;
    run_mret("mret", 32'h1888, 32'h108);

    // vectored irq: 0x200 + 44
    irq_ext = 1; mstatus_in = 32'h8; mtvec_in = 32'h201; req_pc = 32'h40;
    run_trap("irq_vec", 1'b0, 32'h40, 32'h8000_000B, 32'h1880, 32'h22C);

    // vectored irq near top of address space wraps to 0x1C
    irq_ext = 1; mstatus_in = 32'h8; mtvec_in = 32'hFFFF_FFF1; req_pc = 32'h80;
    run_trap("irq_wrap", 1'b0, 32'h80, 32'h8000_000B, 32'h1880, 32'h1C);

    // illegal beats ecall and irq; misaligned pc has low bits forced to zero
    req_valid = 1; illegal_req = 1; ecall_req = 1; irq_ext = 1;
    mstatus_in = 32'h8; mtvec_in = 32'h200; req_pc = 32'h82;
    run_trap("illegal_prio", 1'b1, 32'h80, 32'd2, 32'h1880, 32'h200);
    mstatus_in = 32'h0;
    step();
    check("irq_masked.busy", {31'd0, busy}, 32'd0);
    step();
    check("irq_masked.busy2", {31'd0, busy}, 32'd0);
    irq_ext = 0;

    // ebreak beats mret; vectored mtvec does not offset exceptions; MPP set, MPIE <= 0
    req_valid = 1; ebreak_req = 1; mret_req = 1;
    mstatus_in = 32'h0; mtvec_in = 32'h201; req_pc = 32'h10;
    run_trap("ebreak_prio", 1'b0, 32'h10, 32'd3, 32'h1800, 32'h200);

    // reset during W_MCAUSE aborts the trap
    req_valid = 1; ecall_req = 1; req_pc = 32'h104; mstatus_in = 32'h8; mtvec_in = 32'h200;
    step();
    clear_reqs(1'b0);
    step();
    step();
    check("abort.pre_addr", {20'd0, csr_addr}, 32'h342);
    rst = 1'b1;
    step();
    rst = 1'b0;
    expect_out("abort.reset", 0, 0, 0, 12'h000, 32'h0, 0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      expect_out("abort.quiet", 0, 0, 0, 12'h000, 32'h0, 0, 32'h0);
    end

    // ecall held through busy: ignored until IDLE, then accepted at once
    req_valid = 1; ecall_req = 1; req_pc = 32'h104; mstatus_in = 32'h8; mtvec_in = 32'h200;
    step();
    req_pc = 32'h300;
    for (int i = 0; i < 4; i++) begin
      step();
      check("held.busy", {31'd0, busy}, 32'd1);
    end
    check("held.redir", {31'd0, redirect_valid}, 32'd1);
    step();
    expect_out("held.idle", 0, 0, 0, 12'h000, 32'h0, 0, 32'h0);
    run_trap("held_accept", 1'b0, 32'h300, 32'd11, 32'h1880, 32'h200);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
